bcd_axis_scheduler: RTL and testbench

Shares one iterative shift-add-3 (double-dabble) binary-to-BCD converter among the three gyro axis channels (x, y, z), in place of one combinational decoder per axis. Each axis raises a sample strobe. A round-robin scheduler queues the strobes and runs one conversion at a time. It writes each result into a per-axis BCD register. A display select steers one axis's digits to the seven-segment digit outputs.

---
 rtl/bcd_axis_scheduler_pkg.sv | 58 +++++
 rtl/bcd_serial_converter.sv | 41 ++++
 rtl/bcd_axis_scheduler.sv | 138 +++++++++++++
 tb/tb_bcd_axis_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_axis_scheduler_pkg.sv
// Shared constants, encodings and helpers for the gyro-axis BCD scheduler.
// The converter is built for 16-bit magnitudes and a 5-digit result only.
package bcd_axis_scheduler_pkg;

    localparam int DATA_W = 16;
    localparam int BCD_W  = 20;
    localparam int SR_W   = DATA_W + BCD_W;
    localparam int CNT_W  = 4;
    localparam int DIGITS = BCD_W / 4;

    typedef enum logic [1:0] {
        AX_X    = 2'd0,
        AX_Y    = 2'd1,
        AX_Z    = 2'd2,
        AX_NONE = 2'd3
    } axis_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    // Round-robin choice: first pending axis after 'last' in X->Y->Z order,
    // AX_NONE when nothing is pending.
    function automatic axis_t rr_pick(input logic [2:0] pend, input axis_t last);
        axis_t c0;
        axis_t c1;
        axis_t c2;
        axis_t pick;
        case (last)
            AX_X:    begin c0 = AX_Y; c1 = AX_Z; c2 = AX_X; end
            AX_Y:    begin c0 = AX_Z; c1 = AX_X; c2 = AX_Y; end
            default: begin c0 = AX_X; c1 = AX_Y; c2 = AX_Z; end
        endcase
        if (pend[c0[1:0]])
            pick = c0;
        else if (pend[c1[1:0]])
            pick = c1;
        else if (pend[c2[1:0]])
            pick = c2;
        else
            pick = AX_NONE;
        return pick;
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[DATA_W + 4*i +: 4] >= 4'd5)
                t[DATA_W + 4*i +: 4] = t[DATA_W + 4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_serial_converter.sv
// Iterative shift-add-3 binary-to-BCD converter: one shift per clock,
// 16 shifts per conversion. 'start' loads the operand; 'done' is high in the
// cycle whose edge performs the final shift, so 'bcd' is final in the cycle
// after 'done' and holds until the next 'start'.
module bcd_serial_converter
    import bcd_axis_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // Load on start, then adjust-and-shift until the 16th shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sr  <= {{BCD_W{1'b0}}, bin};
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            sr  <= dd_step(sr);
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15)
                run <= 1'b0;
        end
    end

    assign bcd  = sr[SR_W-1:DATA_W];
    assign done = run && (cnt == 4'd15);

endmodule

// File: rtl/bcd_axis_scheduler.sv
// Shares one serial binary-to-BCD converter among the x/y/z gyro axes.
// Protocol: a single-cycle *_req marks its axis pending (repeats coalesce);
// the scheduler grants pending axes round-robin, samples that axis's data at
// the grant edge, and pulses *_done for one cycle when its BCD register
// updates. Digits D0..D4 show the register chosen by sel (3 = blank).
module bcd_axis_scheduler
    import bcd_axis_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] y_data,
    input  logic [DATA_W-1:0] z_data,
    input  logic              x_req,
    input  logic              y_req,
    input  logic              z_req,
    input  logic [1:0]        sel,
    output logic              busy,
    output logic              x_done,
    output logic              y_done,
    output logic              z_done,
    output logic [3:0]        D0,
    output logic [3:0]        D1,
    output logic [3:0]        D2,
    output logic [3:0]        D3,
    output logic [3:0]        D4
);

    state_t            state;
    axis_t             grant;
    axis_t             last;
    axis_t             pick;
    logic [2:0]        pend;
    logic [2:0]        req_vec;
    logic [2:0]        clr_vec;
    logic              start;
    logic [DATA_W-1:0] conv_bin;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_done;
    logic [BCD_W-1:0]  x_bcd;
    logic [BCD_W-1:0]  y_bcd;
    logic [BCD_W-1:0]  z_bcd;
    logic [BCD_W-1:0]  disp;

    assign req_vec = {z_req, y_req, x_req};
    assign pick    = rr_pick(pend, last);
    assign start   = (state == ST_IDLE) && (pick != AX_NONE);
    assign clr_vec = start ? (3'b001 << pick) : 3'b000;
    assign busy    = (state != ST_IDLE);

    // Operand for the converter comes from the axis being granted this cycle.
    always_comb begin
        conv_bin = '0;
        case (pick)
            AX_X:    conv_bin = x_data;
            AX_Y:    conv_bin = y_data;
            AX_Z:    conv_bin = z_data;
            default: conv_bin = '0;
        endcase
    end

    // Pending flags: a new req wins over a same-edge grant clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend <= 3'b000;
        else
            pend <= (pend & ~clr_vec) | req_vec;
    end

    // Scheduler FSM: grant, wait out the shifts, store and pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            grant  <= AX_X;
            last   <= AX_Z;
            x_bcd  <= '0;
            y_bcd  <= '0;
            z_bcd  <= '0;
            x_done <= 1'b0;
            y_done <= 1'b0;
            z_done <= 1'b0;
        end else begin
            x_done <= 1'b0;
            y_done <= 1'b0;
            z_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        grant <= pick;
                        last  <= pick;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (conv_done)
                        state <= ST_STORE;
                end
                ST_STORE: begin
                    case (grant)
                        AX_X: begin x_bcd <= conv_bcd; x_done <= 1'b1; end
                        AX_Y: begin y_bcd <= conv_bcd; y_done <= 1'b1; end
                        AX_Z: begin z_bcd <= conv_bcd; z_done <= 1'b1; end
                        default: ;
                    endcase
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bcd_serial_converter u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Display mux; result registers only change in STORE, so no partial digits.
    always_comb begin
        disp = '0;
        case (sel)
            2'd0:    disp = x_bcd;
            2'd1:    disp = y_bcd;
            2'd2:    disp = z_bcd;
            default: disp = '0;
        endcase
    end

    assign D0 = disp[19:16];
    assign D1 = disp[15:12];
    assign D2 = disp[11:8];
    assign D3 = disp[7:4];
    assign D4 = disp[3:0];

endmodule

// File: tb/tb_bcd_axis_scheduler.sv
// Bench for bcd_axis_scheduler: table of single-axis conversions, then
// multi-cycle sequences (simultaneous reqs, coalescing, mid-conversion reset,
// round-robin order). Done pulses are checked against an expected queue.
module tb_bcd_axis_scheduler;

    localparam int EW = 22;

    logic        clk;
    logic        rst_n;
    logic [15:0] x_data, y_data, z_data;
    logic        x_req, y_req, z_req;
    logic [1:0]  sel;
    logic        busy;
    logic        x_done, y_done, z_done;
    logic [3:0]  D0, D1, D2, D3, D4;

    bcd_axis_scheduler dut (
        .clk    (clk),
        .rst    (rst_n),
        .x_data (x_data),
        .y_data (y_data),
        .z_data (z_data),
        .x_req  (x_req),
        .y_req  (y_req),
        .z_req  (z_req),
        .sel    (sel),
        .busy   (busy),
        .x_done (x_done),
        .y_done (y_done),
        .z_done (z_done),
        .D0     (D0),
        .D1     (D1),
        .D2     (D2),
        .D3     (D3),
        .D4     (D4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [19:0]   model_reg [3];
    int            done_cnt [3];
    int            pass_cnt;
    int            total_cnt;

    typedef struct {
        int          ax;
        logic [15:0] data;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Monitor: every done pulse pops one expected {axis, bcd} entry.
    always @(negedge clk) begin
        logic [2:0]    dv;
        logic [EW-1:0] e;
        int            ax;
        dv = {z_done, y_done, x_done};
        if (rst_n && dv != 3'b000) begin
            check("one_done_at_a_time", $countones(dv), 1);
            ax = dv[0] ? 0 : (dv[1] ? 1 : 2);
            done_cnt[ax]++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: axis %0d pulsed with nothing expected", ax);
            end else begin
                e = exp_q.pop_front();
                check("done_axis", ax, 32'(e[21:20]));
                model_reg[e[21:20]] = e[19:0];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) model_reg[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_data(input int ax, input logic [15:0] d);
        case (ax)
            0: x_data = d;
            1: y_data = d;
            default: z_data = d;
        endcase
    endtask

    // Req held across exactly one rising edge ("edge 0"); returns at edge0+1.
    task automatic pulse(input logic [2:0] m);
        @(posedge clk);
        #1 {z_req, y_req, x_req} = m;
        @(posedge clk);
        #1 {z_req, y_req, x_req} = 3'b000;
    endtask

    task automatic wait_done(input int ax, output int n, output logic b1, output logic b17);
        logic [2:0] dv;
        n = 0; b1 = 1'b0; b17 = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 1)  b1 = busy;
            if (i == 17) b17 = busy;
            dv = {z_done, y_done, x_done};
            if (dv[ax]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_display(input string tag);
        logic [19:0] exp;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            exp = (s == 3) ? 20'h0 : model_reg[s];
            check({tag, "_sel", $sformatf("%0d", s)}, {D0, D1, D2, D3, D4}, exp);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        logic        b1, b17;
        int          tx, ty, tz;
        int          xc;
        logic        busy_any;
        logic [15:0] d;
        int          ax;

        pass_cnt = 0; total_cnt = 0;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        x_data = '0; y_data = '0; z_data = '0;
        x_req = 0; y_req = 0; z_req = 0; sel = 2'd0;

        vecs[0] = '{0, 16'd360,   20'h00360};
        vecs[1] = '{2, 16'd65535, 20'h65535};
        vecs[2] = '{1, 16'd0,     20'h00000};
        vecs[3] = '{1, 16'd9,     20'h00009};
        vecs[4] = '{0, 16'd10,    20'h00010};
        vecs[5] = '{1, 16'd12345, 20'h12345};
        vecs[6] = '{0, 16'd59999, 20'h59999};
        vecs[7] = '{2, 16'd1000,  20'h01000};
        vecs[8] = '{2, 16'd8,     20'h00008};

        do_reset();
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", {z_done, y_done, x_done}, 0);
        check_display("reset");

        // Table: one axis at a time, 18-edge latency, all displays checked.
        for (int v = 0; v < 9; v++) begin
            set_data(vecs[v].ax, vecs[v].data);
            exp_q.push_back({2'(vecs[v].ax), vecs[v].exp});
            pulse(3'b001 << vecs[v].ax);
            wait_done(vecs[v].ax, n, b1, b17);
            check($sformatf("latency_v%0d", v), n, 18);
            check($sformatf("busy_edge1_v%0d", v), b1, 1);
            check($sformatf("busy_edge17_v%0d", v), b17, 1);
            check($sformatf("busy_after_store_v%0d", v), busy, 0);
            @(negedge clk);
            check_display($sformatf("vec%0d", v));
        end

        // Three reqs on one edge, last grant was Z: X, Y, Z at 18/36/54.
        x_data = 16'd111; y_data = 16'd2222; z_data = 16'd33333;
        exp_q.push_back({2'd0, 20'h00111});
        exp_q.push_back({2'd1, 20'h02222});
        exp_q.push_back({2'd2, 20'h33333});
        pulse(3'b111);
        tx = 0; ty = 0; tz = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (x_done && tx == 0) tx = i;
            if (y_done && ty == 0) ty = i;
            if (z_done && tz == 0) tz = i;
        end
        check("simul_x_edge", tx, 18);
        check("simul_y_edge", ty, 36);
        check("simul_z_edge", tz, 54);
        drain(20);
        check_display("simul");

        // Random single conversions.
        for (int k = 0; k < 4; k++) begin
            ax = $urandom_range(0, 2);
            d  = 16'($urandom_range(0, 65535));
            set_data(ax, d);
            exp_q.push_back({2'(ax), to_bcd(int'(d))});
            pulse(3'b001 << ax);
            wait_done(ax, n, b1, b17);
            check($sformatf("latency_rand%0d", k), n, 18);
            @(negedge clk);
            check_display($sformatf("rand%0d", k));
        end

        // Coalescing: three reqs during an x conversion give one more run.
        xc = done_cnt[0];
        x_data = 16'd100;
        exp_q.push_back({2'd0, 20'h00100});
        pulse(3'b001);
        repeat (3) @(posedge clk);
        #1 x_data = 16'd9999;
        exp_q.push_back({2'd0, 20'h09999});
        pulse(3'b001);
        pulse(3'b001);
        pulse(3'b001);
        drain(80);
        repeat (25) @(posedge clk);
        #1;
        check("coalesce_x_count", done_cnt[0] - xc, 2);
        check("coalesce_idle", busy, 0);
        check_display("coalesce");

        // Reset in the middle of a y conversion with z pending.
        y_data = 16'd4321; z_data = 16'd777;
        pulse(3'b110);
        repeat (8) @(posedge clk);
        #1;
        check("y_running_before_reset", busy, 1);
        do_reset();
        #1;
        check("reset_mid_busy", busy, 0);
        check_display("midreset");
        busy_any = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 busy_any |= busy;
        end
        check("no_start_after_reset", busy_any, 0);

        // Last grant Y with X and Z pending: Z must go before X.
        y_data = 16'd5; x_data = 16'd11; z_data = 16'd22;
        exp_q.push_back({2'd1, 20'h00005});
        pulse(3'b010);
        repeat (3) @(posedge clk);
        exp_q.push_back({2'd2, 20'h00022});
        exp_q.push_back({2'd0, 20'h00011});
        pulse(3'b101);
        drain(80);
        check_display("rr");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
